// File: rtl/puf_rsp_stabilizer.sv
// PUF evaluation sequencer with per-bit majority vote over SAMPLES evaluations.
// Optional PUF_UNSTABLE_MASK_EN adds a mask of bits that disagreed across samples.
module puf_rsp_stabilizer #(
  parameter int WIDTH   = 64,
  parameter int SAMPLES = 15,
  parameter int RST_CYC = 4,
  parameter int SETTLE  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] rsp_raw,
  output logic             puf_rst,
  output logic             busy,
  output logic [WIDTH-1:0] rsp_stb,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] unstable_mask
);

  localparam int CW   = $clog2(SAMPLES + 1);
  localparam int TMAX = (SETTLE > RST_CYC) ? SETTLE : RST_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXCITE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sync1, sync2;
  logic [TW-1:0]    tmr;
  logic [CW-1:0]    scnt;
  logic [CW-1:0]    ones [WIDTH];
  logic [WIDTH-1:0] vote;

  // rsp_raw is asynchronous to clk
  always_ff @(posedge clk) begin
    sync1 <= rsp_raw;
    sync2 <= sync1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_EXCITE;
      S_EXCITE: if (tmr == TW'(RST_CYC - 1)) state_nx = S_SETTLE;
      S_SETTLE: if (tmr == TW'(SETTLE - 1)) state_nx = S_SAMPLE;
      S_SAMPLE: begin
        if (scnt == CW'(SAMPLES - 1)) state_nx = S_DONE;
        else                          state_nx = S_EXCITE;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    puf_rst = 1'b0;
    busy    = 1'b1;
    case (state)
      S_IDLE:   busy    = 1'b0;
      S_EXCITE: puf_rst = 1'b1;
      default:  ;
    endcase
  end

  // Timer restarts on every state change
  always_ff @(posedge clk) begin
    if (rst || state != state_nx) tmr <= '0;
    else if (state == S_EXCITE || state == S_SETTLE)
      tmr <= tmr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || state == S_DONE) scnt <= '0;
    else if (state == S_SAMPLE) scnt <= scnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst || state == S_DONE)
        ones[i] <= '0;
      else if (state == S_SAMPLE)
        ones[i] <= ones[i] + CW'(sync2[i]);
    end
  end

  always_comb begin
    vote = '0;
    for (int i = 0; i < WIDTH; i++)
      vote[i] = (ones[i] > CW'(SAMPLES / 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_stb   <= '0;
    end else begin
      rsp_valid <= (state == S_DONE);
      if (state == S_DONE) rsp_stb <= vote;
    end
  end

`ifdef PUF_UNSTABLE_MASK_EN
  logic [WIDTH-1:0] unst;

  always_comb begin
    unst = '0;
    for (int i = 0; i < WIDTH; i++)
      unst[i] = (ones[i] != '0) && (ones[i] != CW'(SAMPLES));
  end

  always_ff @(posedge clk) begin
    if (rst)                 unstable_mask <= '0;
    else if (state == S_DONE) unstable_mask <= unst;
  end
`else
  assign unstable_mask = '0;
`endif

endmodule

// File: tb/tb_puf_rsp_stabilizer.sv
// Self-checking bench for puf_rsp_stabilizer (SAMPLES=5, RST_CYC=2, SETTLE=4).
// Expected responses come from a per-bit vote count over the applied samples.
module tb_puf_rsp_stabilizer;

  localparam int W   = 64;
  localparam int NS  = 5;
  localparam int LAT = 36;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  rsp_raw = '0;
  logic          puf_rst;
  logic          busy;
  logic [W-1:0]  rsp_stb;
  logic          rsp_valid;
  logic [W-1:0]  unstable_mask;

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0] pats [NS];
  int           lat;
  logic [W-1:0] stb_q, mask_q;
  int           rises[$];
  int           widths[$];

  puf_rsp_stabilizer #(
    .WIDTH(W), .SAMPLES(NS), .RST_CYC(2), .SETTLE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rsp_raw(rsp_raw),
    .puf_rst(puf_rst),
    .busy(busy),
    .rsp_stb(rsp_stb),
    .rsp_valid(rsp_valid),
    .unstable_mask(unstable_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic ref_vote(output logic [W-1:0] s, output logic [W-1:0] m);
    s = '0;
    m = '0;
    for (int b = 0; b < W; b++) begin
      int c = 0;
      for (int j = 0; j < NS; j++) c += int'(pats[j][b]);
      s[b] = (2 * c > NS);
`ifdef PUF_UNSTABLE_MASK_EN
      m[b] = (c > 0) && (c < NS);
`endif
    end
  endtask

  // Issues start now (at a negedge) and follows the request until rsp_valid
  task automatic run_req(input int g1, input int g2);
    int   w = 0;
    logic prev = 1'b0;
    bit   got = 1'b0;
    lat = -1;
    rises.delete();
    widths.delete();
    start = 1'b1;
    rsp_raw = pats[0];
    for (int e = 1; e <= 60 && !got; e++) begin
      @(negedge clk);
      start = (e == g1) || (e == g2);
      if (puf_rst && !prev) begin
        rises.push_back(e);
        if (rises.size() <= NS) rsp_raw = pats[int'(rises.size()) - 1];
      end
      if (puf_rst) w++;
      else if (prev) begin
        widths.push_back(w);
        w = 0;
      end
      prev = puf_rst;
      if (rsp_valid) begin
        got = 1'b1;
        lat = e - 1;
        stb_q = rsp_stb;
        mask_q = unstable_mask;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name);
    logic [W-1:0] es, em;
    ref_vote(es, em);
    nvec++;
    if (lat !== LAT) begin
      nerr++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
    end
    nvec++;
    if (stb_q !== es) begin
      nerr++;
      $display("FAIL %s rsp_stb: got %h want %h", name, stb_q, es);
    end
    nvec++;
    if (mask_q !== em) begin
      nerr++;
      $display("FAIL %s mask: got %h want %h", name, mask_q, em);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({busy, puf_rst, rsp_valid} !== 3'b000) begin
      nerr++;
      $display("FAIL reset ctl: got %b want 000", {busy, puf_rst, rsp_valid});
    end
    nvec++;
    if (rsp_stb !== '0) begin
      nerr++;
      $display("FAIL reset rsp_stb: got %h want 0", rsp_stb);
    end
    nvec++;
    if (unstable_mask !== '0) begin
      nerr++;
      $display("FAIL reset mask: got %h want 0", unstable_mask);
    end
  endtask

  task automatic test_constant();
    for (int j = 0; j < NS; j++) pats[j] = 64'h0123456789ABCDEF;
    run_req(0, 0);
    check_run("constant");
    nvec++;
    if (stb_q !== 64'h0123456789ABCDEF) begin
      nerr++;
      $display("FAIL constant literal: got %h want 0123456789abcdef", stb_q);
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] em;
    pats[0] = 64'h1;
    pats[1] = 64'h0;
    pats[2] = 64'h3;
    pats[3] = 64'h2;
    pats[4] = 64'h1;
`ifdef PUF_UNSTABLE_MASK_EN
    em = 64'h3;
`else
    em = 64'h0;
`endif
    run_req(0, 0);
    check_run("patterns");
    nvec++;
    if (stb_q !== 64'h1 || mask_q !== em) begin
      nerr++;
      $display("FAIL patterns literal: got %h/%h want 1/%h", stb_q, mask_q, em);
    end
  endtask

  task automatic test_puf_rst();
    for (int j = 0; j < NS; j++) pats[j] = rnd64();
    run_req(0, 0);
    nvec++;
    if (rises.size() != NS || widths.size() != NS) begin
      nerr++;
      $display("FAIL pulses: got %0d/%0d want %0d", rises.size(), widths.size(), NS);
    end
    for (int j = 0; j < widths.size(); j++) begin
      nvec++;
      if (widths[j] != 2) begin
        nerr++;
        $display("FAIL pulse_width[%0d]: got %0d want 2", j, widths[j]);
      end
    end
    for (int j = 1; j < rises.size(); j++) begin
      nvec++;
      if (rises[j] - rises[j-1] != 7) begin
        nerr++;
        $display("FAIL pulse_gap[%0d]: got %0d want 7", j, rises[j] - rises[j-1]);
      end
    end
    check_run("puf_rst");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < NS; j++) pats[j] = rnd64();
      run_req(0, 0);
      check_run("random");
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < NS; j++) pats[j] = rnd64();
    run_req(3, 20);
    check_run("glitch");
    for (int j = 0; j < NS; j++) pats[j] = rnd64();
    run_req(0, 0);
    check_run("b2b");
  endtask

  task automatic test_rst_mid();
    logic [W-1:0] prev_stb;
    int           seen = 0;
    prev_stb = rsp_stb;
    for (int j = 0; j < NS; j++) pats[j] = rnd64();
    start = 1'b1;
    rsp_raw = pats[0];
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({busy, puf_rst, rsp_valid} !== 3'b000 || rsp_stb !== '0) begin
      nerr++;
      $display("FAIL rst_mid: got %b/%h want 000/0 (prev %h)",
               {busy, puf_rst, rsp_valid}, rsp_stb, prev_stb);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen += int'(rsp_valid) + int'(busy) + int'(puf_rst);
    end
    nvec++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL rst_mid quiet: got %0d activity want 0", seen);
    end
    for (int j = 0; j < NS; j++) pats[j] = rnd64();
    run_req(0, 0);
    check_run("after_rst");
  endtask

  task automatic test_start_rst();
    int seen = 0;
    start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen += int'(busy) + int'(puf_rst) + int'(rsp_valid);
      @(negedge clk);
    end
    nvec++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL start_rst: got %0d activity want 0", seen);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_constant();
    test_patterns();
    test_puf_rst();
    test_random();
    test_back_to_back();
    test_rst_mid();
    test_start_rst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
